// File: rtl/branch_sequencer.sv
// Conditional-branch controller: borrows the shared ALU to form A-B, decides the branch
// from the difference and opcode, then issues a one-cycle PC load (plus flush when taken).
module branch_sequencer #(
    parameter int N   = 19,
    parameter int M   = 3,
    parameter int AW  = 12,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          br_valid,
    output logic          br_ready,
    input  logic [M:0]    br_opc,
    input  logic [N:0]    br_a,
    input  logic [N:0]    br_b,
    input  logic [AW-1:0] br_pc,
    input  logic [AW-1:0] br_target,
    output logic          alu_req,
    input  logic          alu_gnt,
    output logic [N:0]    alu_a,
    output logic [N:0]    alu_b,
    input  logic          alu_done,
    input  logic [N:0]    alu_result,
    output logic          pc_load,
    output logic [AW-1:0] pc_next,
    output logic          flush,
    output logic          taken,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic [3:0]    CNT_LAST = 4'(TMO - 1);
    localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [N:0]    R_ZERO   = {(N+1){1'b0}};

    // Exactly one of neg/zero/pos holds for any difference; overflow is not corrected.
    function automatic logic branch_cond(input logic [2:0] opc, input logic [N:0] r);
        logic neg_v;
        logic zero_v;
        logic pos_v;
        neg_v  = opc[2] & r[N];
        zero_v = opc[1] & (r == R_ZERO);
        pos_v  = opc[0] & ~r[N] & (r != R_ZERO);
        return neg_v | zero_v | pos_v;
    endfunction

    state_t        state_r;
    state_t        state_d;
    logic [2:0]    opc_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] target_r;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_d;
    logic [N:0]    alu_a_r;
    logic [N:0]    alu_b_r;
    logic          pc_load_r;
    logic [AW-1:0] pc_next_r;
    logic          flush_r;
    logic          taken_r;
    logic          err_r;

    logic          accept_s;
    logic          load_s;
    logic          taken_s;
    logic          err_s;
    logic [AW-1:0] pc_sel_s;
    logic [AW-1:0] tgt_sel_s;
    logic [AW-1:0] next_pc_s;

    // Next-state, decision and timeout-counter logic.
    always_comb begin
        state_d  = state_r;
        cnt_d    = cnt_r;
        accept_s = 1'b0;
        load_s   = 1'b0;
        taken_s  = 1'b0;
        err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (br_valid) begin
                    accept_s = 1'b1;
                    if (br_opc[3]) begin
                        state_d = UPDATE;
                        load_s  = 1'b1;
                        taken_s = 1'b1;
                    end else if (br_opc[2:0] == 3'b000) begin
                        state_d = UPDATE;
                        load_s  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (alu_gnt) begin
                    state_d = WAIT;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                // A result arriving on the last allowed cycle wins over the timeout.
                if (alu_done) begin
                    state_d = UPDATE;
                    load_s  = 1'b1;
                    taken_s = branch_cond(opc_r, alu_result);
                end else if (cnt_r == CNT_LAST) begin
                    state_d = UPDATE;
                    load_s  = 1'b1;
                    err_s   = 1'b1;
                    cnt_d   = cnt_r + 4'd1;
                end else begin
                    cnt_d   = cnt_r + 4'd1;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Direct IDLE->UPDATE branches have not latched yet, so take PC/target from the inputs.
    always_comb begin
        if (state_r == IDLE) begin
            pc_sel_s  = br_pc;
            tgt_sel_s = br_target;
        end else begin
            pc_sel_s  = pc_r;
            tgt_sel_s = target_r;
        end
        next_pc_s = taken_s ? tgt_sel_s : (pc_sel_s + PC_ONE);
    end

    // State, latched branch data and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            opc_r     <= 3'd0;
            pc_r      <= {AW{1'b0}};
            target_r  <= {AW{1'b0}};
            cnt_r     <= 4'd0;
            alu_a_r   <= {(N+1){1'b0}};
            alu_b_r   <= {(N+1){1'b0}};
            pc_load_r <= 1'b0;
            pc_next_r <= {AW{1'b0}};
            flush_r   <= 1'b0;
            taken_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_d;
            cnt_r     <= cnt_d;
            pc_load_r <= load_s;
            flush_r   <= load_s & taken_s;
            err_r     <= err_s;
            if (accept_s) begin
                opc_r    <= br_opc[2:0];
                pc_r     <= br_pc;
                target_r <= br_target;
                alu_a_r  <= br_a;
                alu_b_r  <= br_b;
            end
            if (load_s) begin
                taken_r   <= taken_s;
                pc_next_r <= next_pc_s;
            end
        end
    end

    assign br_ready = (state_r == IDLE);
    assign alu_req  = (state_r == REQ);
    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign pc_load  = pc_load_r;
    assign pc_next  = pc_next_r;
    assign flush    = flush_r;
    assign taken    = taken_r;
    assign err      = err_r;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle controller that executes one conditional branch at a time for the 20-bit datapath. It accepts a branch from decode, borrows the shared ALU through a request/grant handshake to form the subtraction A−B, and evaluates the branch condition from the difference and the opcode. It then issues a one-cycle PC load with the selected next PC and a pipeline flush when the branch is taken. It sits between decode, the ALU arbiter and the PC register.

## Interface
- N, 19, data MSB index; operands and difference are N+1 bits
- M, 3, opcode MSB index; opcode is M+1 bits
- AW, 12, PC width in bits
- TMO, 15, maximum cycles to wait for alu_done before abort (4-bit counter)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  branch presented by decode
- br_ready  out  1  controller can accept a branch; high only in IDLE
- br_opc  in  M+1  bit3 unconditional, bit2 jump-if-negative, bit1 jump-if-zero, bit0 jump-if-positive
- br_a, br_b  in  N+1  compare operands
- br_pc  in  AW  PC of the branch instruction
- br_target  in  AW  jump target
- alu_req  out  1  request for the shared ALU
- alu_gnt  in  1  grant from the ALU arbiter
- alu_a, alu_b  out  N+1  latched operands; ALU computes alu_a − alu_b
- alu_done  in  1  one-cycle strobe: alu_result is valid
- alu_result  in  N+1  difference
- pc_load  out  1  one-cycle strobe to load pc_next
- pc_next  out  AW  next PC
- flush  out  1  one-cycle strobe, coincident with pc_load, asserted when the branch is taken
- taken  out  1  decision; valid while pc_load is high
- err  out  1  one-cycle strobe on ALU timeout

## Operation
- States: IDLE, REQ, WAIT, UPDATE.
- **IDLE**
  - br_ready = 1.
  - On br_valid & br_ready, latch opc, a, b, pc and target.
  - If opc[3] = 1: go to UPDATE with taken = 1; the ALU is not used.
  - Else if opc[2:0] = 000: go to UPDATE with taken = 0; the ALU is not used.
  - Else: go to REQ.
- **REQ**
  - alu_req = 1; alu_a and alu_b drive the latched operands and stay stable until the grant is taken.
  - When alu_gnt is sampled high, go to WAIT and clear the timeout counter.
  - Without a grant, stay in REQ indefinitely; there is no timeout here.
- **WAIT**
  - alu_req = 0; alu_a and alu_b are held.
  - On alu_done, register taken = neg | zero | pos, then go to UPDATE:
    - neg = opc[2] & r[N]
    - zero = opc[1] & (r == 0)
    - pos = opc[0] & ~r[N] & (r != 0)
  - Any alu_done seen outside WAIT is ignored.
  - The counter increments each WAIT cycle without alu_done. When it reaches TMO, pulse err, force taken = 0 and go to UPDATE.
- **UPDATE**
  - pc_load = 1.
  - pc_next = taken ? target : pc + 1. The increment wraps modulo 2^AW, so 0xFFF goes to 0x000.
  - flush = taken. Return to IDLE.
- Only one branch is in flight. br_valid outside IDLE is not consumed; decode holds it.
- Width rules:
  - Sign is bit N of the two's-complement difference; the full N+1 bits are tested for zero.
  - Overflow of A−B is not corrected: the sign bit is taken as-is.
  - Exactly one of neg/zero/pos conditions is true for any r.

## Timing
- Reset, asserted at any time, immediately forces:
  - state = IDLE, br_ready = 1;
  - alu_req = pc_load = flush = taken = err = 0;
  - alu_a, alu_b, pc_next = 0.
- Reset mid-operation aborts the branch: no pc_load, and the latched data is discarded.
- All outputs except br_ready and alu_req are registered. br_ready and alu_req are decoded from the state register only and never depend on inputs combinationally.
- Accept at edge T:
  - ALU branch, best case (alu_gnt high in REQ and alu_done in the first WAIT cycle): REQ at T+1, WAIT at T+2, UPDATE at T+3. pc_load is high in the cycle after T+3 and 3 cycles after accept.
  - Unconditional or never-taken branch: UPDATE immediately after T; pc_load is high 1 cycle after accept.
- Timeout: alu_done absent for TMO consecutive WAIT cycles gives err and pc_load together TMO+1 cycles after WAIT entry.
- Earliest next accept is the cycle after UPDATE, so back-to-back branches are spaced at 2 cycles minimum.
- alu_done in the same cycle the counter hits TMO counts as a result, not a timeout.

## Test plan
- Reset during WAIT with alu_done pending → state IDLE, alu_req 0, no pc_load, br_ready 1 on the next edge.
- opc=0100 (negative), a=5, b=9, pc=0x010, target=0x080 → r=0xFFFFC, taken 1, pc_next 0x080, flush 1, pc_load a single pulse.
- opc=0010 (zero), a=b=0x7FFFF → taken 1. Then opc=0001 with the same operands → taken 0, pc_next 0x011, flush 0.
- opc=1000 with pc=0xFFF → no alu_req ever, pc_next=target, 1-cycle latency. opc=0000 with pc=0xFFF → pc_next 0x000, taken 0.
- alu_gnt withheld 7 cycles → alu_req stays high with alu_a/alu_b stable. alu_done never arrives → err pulse after 15 WAIT cycles, taken 0.
- br_valid held continuously for 3 branches with immediate grant and done → each accepted only in IDLE, exactly one pc_load per branch; a stray alu_done in IDLE is ignored.
